// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared widths, default interrupt vector and FSM state encoding.
package pc_sequencer_pkg;
  localparam int WORD_WIDTH = 32;
  localparam logic [WORD_WIDTH-1:0] IRQ_VECTOR_DEF = 32'h0000_0018;
  typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_e;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch-stage bus between the PC datapath (master) and the sequencer (slave).
// Interrupt signals exist only when PC_SEQ_IRQ_EN is defined.
interface pc_sequencer_if
  import pc_sequencer_pkg::*;
#(
  parameter int WW = WORD_WIDTH,
  parameter int CW = 16
);
  logic [WW-1:0] pc_cur, pc_plus4, branch_addr, pc_next;
  logic hazard_stall, mem_ready, branch_taken;
  logic freeze, flush, fetch_valid;
  logic [CW-1:0] stall_cnt;
`ifdef PC_SEQ_IRQ_EN
  logic irq_req, irq_ack;
  logic [WW-1:0] irq_ret_addr;
`endif
  modport master (
    output pc_cur, pc_plus4, hazard_stall, mem_ready, branch_taken, branch_addr,
`ifdef PC_SEQ_IRQ_EN
    output irq_req, input irq_ack, irq_ret_addr,
`endif
    input pc_next, freeze, flush, fetch_valid, stall_cnt
  );
  modport slave (
    input pc_cur, pc_plus4, hazard_stall, mem_ready, branch_taken, branch_addr,
`ifdef PC_SEQ_IRQ_EN
    input irq_req, output irq_ack, irq_ret_addr,
`endif
    output pc_next, freeze, flush, fetch_valid, stall_cnt
  );
endinterface

// File: rtl/pc_sequencer_sat_counter.sv
// pc_sequencer_sat_counter: enable-driven up counter that sticks at all-ones.
module pc_sequencer_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = (en_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC arbitration for fetch (branch, interrupt, stalls) with pending-redirect hold.
// Interrupt accept is built only when PC_SEQ_IRQ_EN is defined.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
`ifdef PC_SEQ_IRQ_EN
  parameter logic [WORD_WIDTH-1:0] IRQ_VECTOR = IRQ_VECTOR_DEF,
`endif
  parameter int CNT_WIDTH = 16
) (
  input logic clk,
  input logic rst_n,
  pc_sequencer_if.slave bus
);
  state_e state_q, state_d;
  logic [WORD_WIDTH-1:0] pend_q, pend_d, pc_next;
  logic freeze, flush;
`ifdef PC_SEQ_IRQ_EN
  logic [WORD_WIDTH-1:0] ret_q, ret_d;
  logic irq_ack;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= RUN;
      pend_q  <= '0;
`ifdef PC_SEQ_IRQ_EN
      ret_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
`ifdef PC_SEQ_IRQ_EN
      ret_q   <= ret_d;
`endif
    end
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    pc_next = bus.pc_plus4;
    freeze  = 1'b0;
    flush   = 1'b0;
`ifdef PC_SEQ_IRQ_EN
    ret_d   = ret_q;
    irq_ack = 1'b0;
`endif
    if (state_q == PEND) begin
      // The newest redirect wins, even on the cycle memory completes.
      pend_d  = bus.branch_taken ? bus.branch_addr : pend_q;
      pc_next = pend_d;
      freeze  = !bus.mem_ready;
      flush   = 1'b1;
      state_d = bus.mem_ready ? RUN : PEND;
    end else if (bus.branch_taken && bus.mem_ready) begin
      pc_next = bus.branch_addr;
      flush   = 1'b1;
    end else if (bus.branch_taken) begin
      pend_d  = bus.branch_addr;
      freeze  = 1'b1;
      flush   = 1'b1;
      state_d = PEND;
`ifdef PC_SEQ_IRQ_EN
    end else if (bus.irq_req && bus.mem_ready && !bus.hazard_stall) begin
      pc_next = IRQ_VECTOR;
      flush   = 1'b1;
      irq_ack = 1'b1;
      ret_d   = bus.pc_cur;
`endif
    end else begin
      freeze  = !bus.mem_ready || bus.hazard_stall;
    end
  end
  assign bus.pc_next     = pc_next;
  assign bus.freeze      = freeze;
  assign bus.flush       = flush;
  assign bus.fetch_valid = (state_q == RUN) && bus.mem_ready && !flush && !bus.hazard_stall;
`ifdef PC_SEQ_IRQ_EN
  assign bus.irq_ack      = irq_ack;
  assign bus.irq_ret_addr = ret_q;
`endif
  pc_sequencer_sat_counter #(.W(CNT_WIDTH)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .en_i (freeze),
    .cnt_o(bus.stall_cnt)
  );
endmodule
